instruction_stack: RTL and testbench
====================================

Name: instruction_stack

Overview:
- Hardware return-address stack (LIFO) for the CPU's program-counter path.
- On `call` it pushes the current PC.
- On `rtrn` it pops the most recent entry and presents that PC + 1 as the return address on `o_Stack`, which the PC mux loads as the next fetch address.
- The active clock edge is selectable by parameter, so the block can run in either half-cycle of the pipeline.

Parameters:
- addr_width, default 4: log2 of stack depth; depth = 2**addr_width entries (16 by default).
- data_width, default 16: width of PC values and of each stack entry.
- active_edge, default `POS_EDGE (1): sampling edge. `POS_EDGE (1) = rising edge of clk; `NEG_EDGE (0) = falling edge of clk. Macros come from the shared edge macro header.

Ports:
- clk, input, 1: system clock; all state updates on the edge selected by active_edge.
- rst, input, 1: synchronous, active-high reset, sampled on the active edge.
- i_PC, input, data_width: current program counter; value pushed on call.
- call, input, 1: push request.
- rtrn, input, 1: pop/return request.
- o_Stack, output, data_width: registered return address (popped entry + 1).

Behaviour:
- Storage: array of 2**addr_width entries, each data_width wide. Stack pointer sp is addr_width+1 bits and holds the count of valid entries (0..depth).
- Single clock domain. All updates happen only on the active edge: posedge when active_edge=1, negedge when active_edge=0. Nothing changes on the other edge.
- Reset:
  - rst=1 at an active edge sets sp=0 and o_Stack=0. Memory contents are don't-care.
  - rst has priority over call/rtrn.
  - A rst pulse that contains no active edge has no effect.
- Push (call=1, rtrn=0, sp<depth):
  - mem[sp] <= i_PC; sp <= sp+1.
  - o_Stack unchanged.
  - call held high across N active edges pushes N entries (level-sensitive, one push per edge).
- Pop (rtrn=1, call=0, sp>0):
  - o_Stack <= mem[sp-1] + 1; sp <= sp-1.
  - Addition wraps modulo 2**data_width.
  - o_Stack is valid immediately after that active edge (1-edge latency).
  - One pop per active edge while rtrn is held.
- Hold: when call=rtrn=0, state and o_Stack are unchanged.
- Simultaneous call=1 and rtrn=1: no operation; sp and o_Stack hold.
- Overflow: push with sp=depth is ignored; sp stays at depth and contents are preserved.
- Underflow: pop with sp=0 is ignored; sp stays 0 and o_Stack holds its last value.
- LIFO order is strict: the k-th pop returns the (k-th most recent unpopped push)+1.
- i_PC is sampled only at the active edge. Changes between edges have no effect.

Test Plan:
- Reset: rst=1 across one active edge → o_Stack=0, sp=0. Pop immediately after → o_Stack stays 0.
- Single call/return:
  - i_PC=10, call=1 for one active edge, then call=0.
  - rtrn=1, i_PC=0, one active edge → o_Stack=11.
  - Run on both a posedge and a negedge instance; each updates only on its own edge.
- Nested calls:
  - Push i_PC=0x10,0x20,…,0x90, one per active edge.
  - Then rtrn held → successive o_Stack = 0x91,0x81,0x71,…,0x21,0x11, one per active edge.
- Edge selection: drive a stimulus change just after a posedge → posedge instance reacts at the next posedge only; negedge instance reacts at the next negedge only.
- Boundaries:
  - Push 17 distinct values into a depth-16 stack → the 17th is ignored; 16 pops return entries 16..1 (+1 each).
  - A further pop leaves o_Stack unchanged.
  - Push 0xFFFF then pop → o_Stack=0x0000 (wrap).
- Conflict and reset:
  - call=rtrn=1 for one edge → no change.
  - rst asserted mid-sequence after 3 pushes → sp=0, o_Stack=0; a subsequent pop is ignored.

Source files
------------

// File: rtl/instruction_stack.sv
// Return-address stack for the PC path: call pushes i_PC, rtrn pops and
// presents the popped entry + 1 on o_Stack. Active clock edge is a parameter.

`ifndef POS_EDGE
`define POS_EDGE 1
`endif
`ifndef NEG_EDGE
`define NEG_EDGE 0
`endif

module instruction_stack #(
    parameter int addr_width  = 4,
    parameter int data_width  = 16,
    parameter bit active_edge = `POS_EDGE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] i_PC,
    input  logic                  call,
    input  logic                  rtrn,
    output logic [data_width-1:0] o_Stack
);

    localparam int                DEPTH   = 2 ** addr_width;
    localparam logic [addr_width:0] SP_FULL = DEPTH[addr_width:0];

    logic [data_width-1:0] mem [DEPTH];
    logic [addr_width:0]   sp;
    logic [addr_width:0]   sp_next;
    logic [data_width-1:0] stack_next;
    logic [addr_width-1:0] wr_idx;
    logic [addr_width-1:0] top_idx;
    logic                  push_ok;
    logic                  pop_ok;

    // Low bits of sp address the next free slot; sp==DEPTH wraps to 0 but push
    // is blocked there, and top_idx (sp-1) still lands on DEPTH-1.
    assign wr_idx  = sp[addr_width-1:0];
    assign top_idx = sp[addr_width-1:0] - 1'b1;
    assign push_ok = call && !rtrn && (sp != SP_FULL);
    assign pop_ok  = rtrn && !call && (sp != '0);

    always_comb begin
        sp_next    = sp;
        stack_next = o_Stack;
        if (push_ok) begin
            sp_next = sp + 1'b1;
        end else if (pop_ok) begin
            sp_next    = sp - 1'b1;
            stack_next = mem[top_idx] + data_width'(1);
        end
    end

    // Only one of these register sets exists; it selects the sampling edge.
    generate
        if (active_edge == `POS_EDGE) begin : g_pos
            always_ff @(posedge clk) begin
                if (rst) begin
                    sp      <= '0;
                    o_Stack <= '0;
                end else begin
                    sp      <= sp_next;
                    o_Stack <= stack_next;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst && push_ok) begin
                    mem[wr_idx] <= i_PC;
                end
            end
        end else begin : g_neg
            always_ff @(negedge clk) begin
                if (rst) begin
                    sp      <= '0;
                    o_Stack <= '0;
                end else begin
                    sp      <= sp_next;
                    o_Stack <= stack_next;
                end
            end

            always_ff @(negedge clk) begin
                if (!rst && push_ok) begin
                    mem[wr_idx] <= i_PC;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_instruction_stack.sv
// Bench for instruction_stack: a directed vector table applied to a posedge and
// a negedge instance, plus overflow, edge-selection and reset-glitch sequences.

`ifndef POS_EDGE
`define POS_EDGE 1
`endif
`ifndef NEG_EDGE
`define NEG_EDGE 0
`endif

module tb_instruction_stack;

    logic        clk = 1'b0;
    logic        p_rst = 1'b0, p_call = 1'b0, p_rtrn = 1'b0;
    logic [15:0] p_pc = '0;
    logic [15:0] p_o;
    logic        n_rst = 1'b0, n_call = 1'b0, n_rtrn = 1'b0;
    logic [15:0] n_pc = '0;
    logic [15:0] n_o;

    int vec_count = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instruction_stack #(.addr_width(4), .data_width(16), .active_edge(`POS_EDGE)) dut_pos (
        .clk(clk), .rst(p_rst), .i_PC(p_pc), .call(p_call), .rtrn(p_rtrn), .o_Stack(p_o)
    );

    instruction_stack #(.addr_width(4), .data_width(16), .active_edge(`NEG_EDGE)) dut_neg (
        .clk(clk), .rst(n_rst), .i_PC(n_pc), .call(n_call), .rtrn(n_rtrn), .o_Stack(n_o)
    );

    typedef struct {
        logic        rst;
        logic        call;
        logic        rtrn;
        logic [15:0] pc;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic r, input logic c, input logic t,
                                    input logic [15:0] pc, input logic [15:0] exp);
        vec_t v;
        v.rst = r; v.call = c; v.rtrn = t; v.pc = pc; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: o_Stack=0x%04h expected 0x%04h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive after the opposite edge, return 1 time unit after the active edge.
    task automatic pos_step(input logic r, input logic c, input logic t, input logic [15:0] pc);
        @(negedge clk);
        p_rst = r; p_call = c; p_rtrn = t; p_pc = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic neg_step(input logic r, input logic c, input logic t, input logic [15:0] pc);
        @(posedge clk);
        n_rst = r; n_call = c; n_rtrn = t; n_pc = pc;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Directed table: each row is one active edge and the o_Stack after it.
        add_vec(1, 0, 0, 16'h0000, 16'h0000);   // reset
        add_vec(0, 0, 1, 16'h0000, 16'h0000);   // pop on empty ignored
        add_vec(0, 1, 0, 16'h000A, 16'h0000);   // push 10
        add_vec(0, 0, 0, 16'h0005, 16'h0000);   // idle, pc ignored
        add_vec(0, 0, 1, 16'h0000, 16'h000B);   // return 11
        add_vec(0, 1, 0, 16'h1234, 16'h000B);
        add_vec(0, 1, 1, 16'h0055, 16'h000B);   // call+rtrn: no-op
        add_vec(0, 0, 1, 16'h0000, 16'h1235);   // 0x55 was not pushed
        add_vec(0, 0, 1, 16'h0000, 16'h1235);   // underflow holds
        add_vec(0, 1, 0, 16'hFFFF, 16'h1235);
        add_vec(0, 0, 1, 16'h0000, 16'h0000);   // wrap
        for (int i = 1; i <= 9; i++) add_vec(0, 1, 0, 16'(i * 16), 16'h0000);
        for (int i = 9; i >= 1; i--) add_vec(0, 0, 1, 16'h0000, 16'(i * 16 + 1));
        add_vec(0, 0, 1, 16'h0000, 16'h0011);   // empty again
        add_vec(0, 1, 0, 16'h000A, 16'h0011);
        add_vec(0, 1, 0, 16'h000B, 16'h0011);
        add_vec(0, 1, 0, 16'h000C, 16'h0011);
        add_vec(1, 1, 0, 16'h000D, 16'h0000);   // reset wins over call
        add_vec(0, 0, 1, 16'h0000, 16'h0000);   // stack emptied by reset
        add_vec(0, 1, 0, 16'h0042, 16'h0000);
        add_vec(0, 0, 1, 16'h0000, 16'h0043);
        add_vec(0, 0, 1, 16'h0000, 16'h0043);

        foreach (vecs[i]) begin
            pos_step(vecs[i].rst, vecs[i].call, vecs[i].rtrn, vecs[i].pc);
            check($sformatf("pos_vec%0d", i), p_o, vecs[i].exp);
        end
        foreach (vecs[i]) begin
            neg_step(vecs[i].rst, vecs[i].call, vecs[i].rtrn, vecs[i].pc);
            check($sformatf("neg_vec%0d", i), n_o, vecs[i].exp);
        end

        // Overflow: 17 pushes into 16 entries, the last is dropped.
        pos_step(1, 0, 0, 16'h0000);
        for (int i = 0; i < 17; i++) pos_step(0, 1, 0, 16'(16'h0100 + i));
        check("ovf_after_push", p_o, 16'h0000);
        for (int k = 0; k < 16; k++) begin
            pos_step(0, 0, 1, 16'h0000);
            check($sformatf("ovf_pop%0d", k), p_o, 16'(16'h0100 + 15 - k + 1));
        end
        pos_step(0, 0, 1, 16'h0000);
        check("ovf_extra_pop", p_o, 16'h0101);

        // A reset pulse between active edges must not reach the posedge instance.
        pos_step(0, 1, 0, 16'h2000);
        p_call = 1'b0;
        #3 p_rst = 1'b1;
        #2 p_rst = 1'b0;
        pos_step(0, 0, 1, 16'h0000);
        check("rst_glitch", p_o, 16'h2001);

        // Edge selection: both instances hold one entry (10) with o_Stack=0.
        pos_step(1, 0, 0, 16'h0000);
        pos_step(0, 1, 0, 16'h000A);
        p_call = 1'b0;
        neg_step(1, 0, 0, 16'h0000);
        neg_step(0, 1, 0, 16'h000A);
        n_call = 1'b0;
        @(posedge clk);
        #1;
        p_rtrn = 1'b1;
        n_rtrn = 1'b1;
        @(negedge clk);
        #1;
        check("edge_neg_reacts", n_o, 16'h000B);
        check("edge_pos_waits", p_o, 16'h0000);
        n_rtrn = 1'b0;
        @(posedge clk);
        #1;
        check("edge_pos_reacts", p_o, 16'h000B);
        check("edge_neg_holds", n_o, 16'h000B);
        p_rtrn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
